rect_fill_engine: RTL and testbench
===================================

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter X_W, default 9, x coordinate width.
REQ-002 Parameter Y_W, default 8, y coordinate width.
REQ-003 Parameter COLOUR_W, default 6, pixel colour width (2 bits per channel).
REQ-004 Parameter X_MAX, default 319, last visible column.
REQ-005 Parameter Y_MAX, default 239, last visible row.
REQ-006 Clock  in  1  single system clock; all logic on rising edge.
REQ-007 Resetn  in  1  synchronous, active-low reset.
REQ-008 cmdValid  in  1  command present; cmdReady  out  1  engine can accept.
REQ-009 cmdX  in  X_W, cmdY  in  Y_W  rectangle origin (top-left).
REQ-010 cmdW  in  X_W, cmdH  in  Y_W  rectangle width/height in pixels.
REQ-011 cmdMode  in  2  00 solid, 01 outline, 10 checker, 11 treated as solid.
REQ-012 cmdColourA, cmdColourB  in  COLOUR_W each  primary/secondary colour.
REQ-013 abort  in  1  terminate current rectangle.
REQ-014 xOut  out  X_W, yOut  out  Y_W, colourOut  out  COLOUR_W, plotOut  out  1  pixel write to VGA adapter.
REQ-015 busy  out  1  command in progress; done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, CLIP, DRAW, FIN.
REQ-017 cmdReady SHALL equal (state==IDLE); a command is accepted on the cycle cmdValid & cmdReady; all cmd* fields latched then.
REQ-018 IDLE->CLIP on accept; CLIP lasts exactly one cycle.
REQ-019 CLIP SHALL compute xEnd=min(cmdX+cmdW-1, X_MAX), yEnd=min(cmdY+cmdH-1, Y_MAX) in X_W+1 / Y_W+1 bits (no wrap).
REQ-020 If cmdW==0, cmdH==0, cmdX>X_MAX or cmdY>Y_MAX, CLIP->FIN with no pixel plotted; else CLIP->DRAW.
REQ-021 DRAW SHALL raster-scan one pixel per cycle, x fastest, from (cmdX,cmdY) to (xEnd,yEnd); x returns to cmdX on row increment.
REQ-022 Outputs xOut/yOut/colourOut/plotOut SHALL be registered; first pixel appears the cycle after the CLIP cycle (2 cycles after accept).
REQ-023 Solid: plotOut=1 every scanned pixel, colour A.
REQ-024 Outline: scan all pixels; plotOut=1 only where x==cmdX, x==xEnd, y==cmdY or y==yEnd; colourOut=A.
REQ-025 Checker: plotOut=1 every pixel; colour A when (col+row) LSB==0, else B, col/row relative to origin.
REQ-026 DRAW->FIN after the pixel (xEnd,yEnd) is emitted; total DRAW cycles = (xEnd-cmdX+1)*(yEnd-cmdY+1).
REQ-027 FIN SHALL last one cycle with done=1, then IDLE; done never high outside FIN.
REQ-028 busy SHALL be 1 in CLIP, DRAW, FIN.
REQ-029 abort in CLIP or DRAW SHALL force plotOut=0 from the next cycle and go to FIN (done pulses); abort in IDLE/FIN ignored.
REQ-030 abort and cmdValid together in IDLE: command accepted, abort ignored.
REQ-031 plotOut SHALL be 0 in IDLE, CLIP and FIN.

Reset
REQ-032 On Resetn==0 at a clock edge: state=IDLE, xOut=0, yOut=0, colourOut=0, plotOut=0, busy=0, done=0, cmdReady=1 after release.
REQ-033 Reset mid-DRAW SHALL discard the command with no done pulse.

Structure
REQ-034 State encoding, mode constants (MODE_SOLID, MODE_OUTLINE, MODE_CHECKER) and default X_MAX/Y_MAX SHALL live in shared package fill_pkg.
REQ-035 Raster x/y counters with row/column wrap SHALL be one sub-module, raster_scan.

Verification
REQ-036 Solid 3x2 at (10,20), colour 6'h30 -> 6 plots (10..12,20),(10..12,21) on consecutive cycles, first 2 cycles after accept, done 1 cycle after last.
REQ-037 Outline 4x4 at (0,0) -> 16 DRAW cycles, 12 plots, interior (1..2,1..2) not plotted.
REQ-038 Checker 2x2 at (5,5), A=6'h3F, B=6'h00 -> colours A,B,B,A in scan order.
REQ-039 Solid 10x10 at (315,235) -> clipped to 5x5, 25 plots, max coords (319,239); cmdW=0 -> no plots, done 2 cycles after accept.
REQ-040 Abort on 3rd pixel of 8x1 -> exactly 3 plots, plotOut low next cycle, done pulses once.
REQ-041 Resetn low mid-DRAW -> next cycle plotOut=0, busy=0, no done; new command then accepted normally.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared definitions for the rectangle fill engine: FSM encoding, fill modes
// and the default visible-area limits.
package fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_DRAW = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SOLID   = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CHECKER = 2'b10;

    localparam int DEF_X_MAX = 319;
    localparam int DEF_Y_MAX = 239;

endpackage

// File: rtl/raster_scan.sv
// Raster position counter: x runs fastest, wrapping back to the row start
// column and advancing y when it reaches the row end.
module raster_scan
    import fill_pkg::*;
#(
    parameter int X_W = 9,
    parameter int Y_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [X_W-1:0] x_load_i,
    input  logic [Y_W-1:0] y_load_i,
    input  logic [X_W-1:0] x_start_i,
    input  logic [X_W-1:0] x_end_i,
    input  logic [Y_W-1:0] y_end_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load_i) begin
            x_q <= x_load_i;
            y_q <= y_load_i;
        end else if (step_i) begin
            if (x_q == x_end_i) begin
                x_q <= x_start_i;
                y_q <= y_q + Y_W'(1);
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x_end_i) && (y_q == y_end_i);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts a rectangle command, clips it to the visible
// area and emits one registered pixel write per cycle in raster order.
//
// state | meaning
// IDLE  | ready for a command
// CLIP  | clip rectangle end to the visible area (one cycle)
// DRAW  | one pixel per cycle, x fastest
// FIN   | one-cycle done pulse
module rect_fill_engine
    import fill_pkg::*;
#(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 6,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int Y_MAX    = DEF_Y_MAX
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [X_W-1:0]      cmdX,
    input  logic [Y_W-1:0]      cmdY,
    input  logic [X_W-1:0]      cmdW,
    input  logic [Y_W-1:0]      cmdH,
    input  logic [1:0]          cmdMode,
    input  logic [COLOUR_W-1:0] cmdColourA,
    input  logic [COLOUR_W-1:0] cmdColourB,
    input  logic                abort,
    output logic [X_W-1:0]      xOut,
    output logic [Y_W-1:0]      yOut,
    output logic [COLOUR_W-1:0] colourOut,
    output logic                plotOut,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] X_MAX_EXT = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_MAX_EXT = (Y_W+1)'(Y_MAX);

    state_t              state_q;
    logic [X_W-1:0]      cmd_x_q, cmd_w_q, x_end_q;
    logic [Y_W-1:0]      cmd_y_q, cmd_h_q, y_end_q;
    logic [1:0]          mode_q;
    logic [COLOUR_W-1:0] colour_a_q, colour_b_q, colour_q;
    logic [X_W-1:0]      x_out_q;
    logic [Y_W-1:0]      y_out_q;
    logic                plot_q, last_q;

    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic [X_W-1:0]      x_end_clip, x_end_cur, scan_x;
    logic [Y_W-1:0]      y_end_clip, y_end_cur, scan_y;
    logic                empty, accept, scan_step, scan_last;
    logic                edge_px, parity, pix_plot;
    logic [COLOUR_W-1:0] pix_colour;

    assign accept = cmdValid && (state_q == ST_IDLE);

    // Sums are one bit wider than the coordinates so far-edge clipping never wraps.
    always_comb begin
        x_sum      = {1'b0, cmd_x_q} + {1'b0, cmd_w_q} - (X_W+1)'(1);
        y_sum      = {1'b0, cmd_y_q} + {1'b0, cmd_h_q} - (Y_W+1)'(1);
        x_end_clip = (x_sum > X_MAX_EXT) ? X_MAX_EXT[X_W-1:0] : x_sum[X_W-1:0];
        y_end_clip = (y_sum > Y_MAX_EXT) ? Y_MAX_EXT[Y_W-1:0] : y_sum[Y_W-1:0];
        empty      = (cmd_w_q == '0) || (cmd_h_q == '0) ||
                     ({1'b0, cmd_x_q} > X_MAX_EXT) || ({1'b0, cmd_y_q} > Y_MAX_EXT);
        x_end_cur  = (state_q == ST_CLIP) ? x_end_clip : x_end_q;
        y_end_cur  = (state_q == ST_CLIP) ? y_end_clip : y_end_q;
    end

    // The counter sits on the origin during CLIP so the first pixel lands the next cycle.
    assign scan_step = !abort &&
                       (((state_q == ST_CLIP) && !empty) || ((state_q == ST_DRAW) && !last_q));

    raster_scan #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk_i     (Clock),
        .rst_n_i   (Resetn),
        .load_i    (accept),
        .step_i    (scan_step),
        .x_load_i  (cmdX),
        .y_load_i  (cmdY),
        .x_start_i (cmd_x_q),
        .x_end_i   (x_end_cur),
        .y_end_i   (y_end_cur),
        .x_o       (scan_x),
        .y_o       (scan_y),
        .last_o    (scan_last)
    );

    always_comb begin
        edge_px = (scan_x == cmd_x_q) || (scan_x == x_end_cur) ||
                  (scan_y == cmd_y_q) || (scan_y == y_end_cur);
        parity  = scan_x[0] ^ cmd_x_q[0] ^ scan_y[0] ^ cmd_y_q[0];
        pix_plot   = 1'b1;
        pix_colour = colour_a_q;
        case (mode_q)
            MODE_SOLID:   pix_plot = 1'b1;
            MODE_OUTLINE: pix_plot = edge_px;
            MODE_CHECKER: pix_colour = parity ? colour_b_q : colour_a_q;
            default:      pix_plot = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            cmd_x_q    <= '0;
            cmd_y_q    <= '0;
            cmd_w_q    <= '0;
            cmd_h_q    <= '0;
            mode_q     <= MODE_SOLID;
            colour_a_q <= '0;
            colour_b_q <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_x_q    <= cmdX;
                        cmd_y_q    <= cmdY;
                        cmd_w_q    <= cmdW;
                        cmd_h_q    <= cmdH;
                        mode_q     <= cmdMode;
                        colour_a_q <= cmdColourA;
                        colour_b_q <= cmdColourB;
                        state_q    <= ST_CLIP;
                    end
                end
                ST_CLIP: begin
                    if (abort || empty) begin
                        state_q <= ST_FIN;
                    end else begin
                        x_end_q  <= x_end_clip;
                        y_end_q  <= y_end_clip;
                        x_out_q  <= scan_x;
                        y_out_q  <= scan_y;
                        colour_q <= pix_colour;
                        plot_q   <= pix_plot;
                        last_q   <= scan_last;
                        state_q  <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (abort || last_q) begin
                        state_q <= ST_FIN;
                    end else begin
                        x_out_q  <= scan_x;
                        y_out_q  <= scan_y;
                        colour_q <= pix_colour;
                        plot_q   <= pix_plot;
                        last_q   <= scan_last;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmdReady  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign xOut      = x_out_q;
    assign yOut      = y_out_q;
    assign colourOut = colour_q;
    assign plotOut   = plot_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: fixed rectangles with hand-computed
// pixel lists, clipping, abort and reset cases.
module tb_rect_fill_engine;

    localparam int LIMIT = 64;

    logic       Clock = 1'b0;
    logic       Resetn, cmdValid, abort;
    logic       cmdReady, plotOut, busy, done;
    logic [8:0] cmdX, cmdW, xOut;
    logic [7:0] cmdY, cmdH, yOut;
    logic [1:0] cmdMode;
    logic [5:0] cmdColourA, cmdColourB, colourOut;

    int errors = 0;
    int checks = 0;
    int q_x[$], q_y[$], q_c[$], q_cyc[$];
    int done_cyc, busy_low, cnt;

    always #5 Clock = ~Clock;

    rect_fill_engine dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdX       (cmdX),
        .cmdY       (cmdY),
        .cmdW       (cmdW),
        .cmdH       (cmdH),
        .cmdMode    (cmdMode),
        .cmdColourA (cmdColourA),
        .cmdColourB (cmdColourB),
        .abort      (abort),
        .xOut       (xOut),
        .yOut       (yOut),
        .colourOut  (colourOut),
        .plotOut    (plotOut),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns #1 after the accept edge (CLIP cycle).
    task automatic issue(input int x, input int y, input int w, input int h,
                         input int m, input int a, input int b, input bit ab);
        cmdX = 9'(x); cmdY = 8'(y); cmdW = 9'(w); cmdH = 8'(h);
        cmdMode = 2'(m); cmdColourA = 6'(a); cmdColourB = 6'(b);
        cmdValid = 1'b1;
        abort = ab;
        @(posedge Clock); #1;
        cmdValid = 1'b0;
        abort = 1'b0;
        chk("clip_busy", busy, 1);
        chk("clip_plot", plotOut, 0);
        chk("clip_ready", cmdReady, 0);
    endtask

    // Record plots until done; cycle numbers count from the accept edge.
    task automatic capture(input int abort_at);
        q_x.delete(); q_y.delete(); q_c.delete(); q_cyc.delete();
        done_cyc = -1;
        busy_low = 0;
        for (int k = 2; k <= LIMIT; k++) begin
            @(posedge Clock); #1;
            abort = 1'b0;
            if (plotOut === 1'b1) begin
                q_x.push_back(int'(xOut));
                q_y.push_back(int'(yOut));
                q_c.push_back(int'(colourOut));
                q_cyc.push_back(k);
            end
            if (busy !== 1'b1) busy_low++;
            if (k == abort_at) abort = 1'b1;
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
        chk("busy_gap", busy_low, 0);
        @(posedge Clock); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmdReady, 1);
    endtask

    initial begin
        Resetn = 1'b0; cmdValid = 1'b0; abort = 1'b0;
        cmdX = '0; cmdY = '0; cmdW = '0; cmdH = '0;
        cmdMode = '0; cmdColourA = '0; cmdColourB = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_x", xOut, 0);
        chk("rst_y", yOut, 0);
        chk("rst_colour", colourOut, 0);
        chk("rst_plot", plotOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        Resetn = 1'b1;
        @(posedge Clock); #1;
        chk("rst_ready", cmdReady, 1);

        // Solid 3x2 at (10,20)
        issue(10, 20, 3, 2, 0, 'h30, 'h0C, 1'b0);
        capture(0);
        chk("solid_count", q_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < q_x.size()) begin
                chk("solid_x", q_x[i], 10 + i % 3);
                chk("solid_y", q_y[i], 20 + i / 3);
                chk("solid_colour", q_c[i], 'h30);
                chk("solid_cycle", q_cyc[i], 2 + i);
            end
        end
        chk("solid_done", done_cyc, 8);

        // Outline 4x4 at (0,0)
        issue(0, 0, 4, 4, 1, 'h21, 'h12, 1'b0);
        capture(0);
        chk("outline_draw_cycles", done_cyc - 2, 16);
        chk("outline_count", q_x.size(), 12);
        cnt = 0;
        foreach (q_x[i]) begin
            if (q_x[i] >= 1 && q_x[i] <= 2 && q_y[i] >= 1 && q_y[i] <= 2) cnt++;
            if (q_c[i] != 'h21) cnt++;
        end
        chk("outline_interior_or_colour", cnt, 0);

        // Checker 2x2 at (5,5)
        issue(5, 5, 2, 2, 2, 'h3F, 'h00, 1'b0);
        capture(0);
        chk("checker_count", q_c.size(), 4);
        if (q_c.size() == 4) begin
            chk("checker_c0", q_c[0], 'h3F);
            chk("checker_c1", q_c[1], 'h00);
            chk("checker_c2", q_c[2], 'h00);
            chk("checker_c3", q_c[3], 'h3F);
        end

        // Mode 11 behaves as solid
        issue(0, 0, 2, 1, 3, 'h2A, 'h15, 1'b0);
        capture(0);
        chk("mode3_count", q_c.size(), 2);
        if (q_c.size() == 2) begin
            chk("mode3_c0", q_c[0], 'h2A);
            chk("mode3_c1", q_c[1], 'h2A);
        end

        // Solid 10x10 at (315,235) clips to 5x5
        issue(315, 235, 10, 10, 0, 'h07, 'h00, 1'b0);
        capture(0);
        chk("clip_count", q_x.size(), 25);
        chk("clip_done", done_cyc, 27);
        if (q_x.size() == 25) begin
            chk("clip_first_x", q_x[0], 315);
            chk("clip_first_y", q_y[0], 235);
            chk("clip_wrap_x", q_x[5], 315);
            chk("clip_wrap_y", q_y[5], 236);
            chk("clip_last_x", q_x[24], 319);
            chk("clip_last_y", q_y[24], 239);
        end

        // Zero width and off-screen origin produce no pixels
        issue(40, 40, 0, 5, 0, 'h01, 'h00, 1'b0);
        capture(0);
        chk("zero_w_count", q_x.size(), 0);
        chk("zero_w_done", done_cyc, 2);
        issue(320, 0, 4, 4, 0, 'h01, 'h00, 1'b0);
        capture(0);
        chk("offscreen_count", q_x.size(), 0);
        chk("offscreen_done", done_cyc, 2);

        // Abort on the 3rd pixel of 8x1
        issue(100, 50, 8, 1, 0, 'h1E, 'h00, 1'b0);
        capture(4);
        chk("abort_count", q_x.size(), 3);
        chk("abort_done", done_cyc, 5);
        if (q_x.size() == 3) begin
            chk("abort_last_x", q_x[2], 102);
            chk("abort_last_cycle", q_cyc[2], 4);
        end

        // Abort alongside the command in IDLE is ignored
        issue(1, 1, 2, 1, 0, 'h11, 'h00, 1'b1);
        capture(0);
        chk("idle_abort_count", q_x.size(), 2);
        chk("idle_abort_done", done_cyc, 4);

        // Reset mid-DRAW
        issue(0, 0, 8, 1, 0, 'h0C, 'h00, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        chk("pre_reset_plot", plotOut, 1);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        chk("mid_reset_plot", plotOut, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_done", done, 0);
        Resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clock); #1;
            if (done !== 1'b0 || plotOut !== 1'b0) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);
        chk("post_reset_ready", cmdReady, 1);
        issue(7, 9, 1, 1, 0, 'h15, 'h00, 1'b0);
        capture(0);
        chk("post_reset_count", q_x.size(), 1);
        chk("post_reset_done", done_cyc, 3);
        if (q_x.size() == 1) begin
            chk("post_reset_x", q_x[0], 7);
            chk("post_reset_y", q_y[0], 9);
            chk("post_reset_colour", q_c[0], 'h15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
